// File: rtl/aes256_key_sched.sv
// aes256_key_sched: sequential AES-256 key scheduler streaming 15 round keys over valid/ready
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   key_i        256-bit cipher key, bit 0 = MSB of byte 0
//   key_v_i      key_i valid; accepted when key_ready_o is high
//   key_ready_o  high only in IDLE
//   rk_o         current 128-bit round key
//   rk_idx_o     index of rk_o (0..14)
//   rk_last_o    marks the final round key of the stream
//   rk_v_o       rk_o valid
//   rk_ready_i   consumer accepts rk_o
//   busy_o       high whenever not IDLE
//   dir_i        (AES_KS_REVERSE_EN only) 0 = forward, 1 = reverse order, sampled on key accept
// Optional feature macro: AES_KS_REVERSE_EN adds dir_i, a 15-entry round-key buffer and an
// EXPAND state so keys can be streamed 14 down to 0 for decryption.
module aes256_key_sched (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic [0:255] key_i,
    input  logic         key_v_i,
`ifdef AES_KS_REVERSE_EN
    input  logic         dir_i,
`endif
    output logic         key_ready_o,
    output logic [0:127] rk_o,
    output logic [0:3]   rk_idx_o,
    output logic         rk_last_o,
    output logic         rk_v_o,
    input  logic         rk_ready_i,
    output logic         busy_o
);
    localparam int NUM_RK = 15;
    localparam int IDX_W  = 4;
    localparam logic [0:IDX_W-1] LAST_IDX = IDX_W'(NUM_RK - 1);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {IDLE, EMIT_LO, EMIT_HI, EXPAND, EMIT_BUF} state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {sub_byte(w[0:7]), sub_byte(w[8:15]), sub_byte(w[16:23]), sub_byte(w[24:31])};
    endfunction

    // One 8-word expansion step: words 0..3 chain from RotWord/SubWord of the previous
    // word 7 plus Rcon, words 4..7 chain from SubWord of the new word 3.
    function automatic logic [0:255] round_key(input logic [0:255] k, input logic [0:4] r);
        logic [0:255] res;
        logic [0:31]  t;
        logic [7:0]   rc;
        rc = 8'h01 << (r - 5'd1);
        t = sub_word({k[232:255], k[224:231]}) ^ {rc, 24'h0};
        res[0:31]    = k[0:31]    ^ t;
        res[32:63]   = k[32:63]   ^ res[0:31];
        res[64:95]   = k[64:95]   ^ res[32:63];
        res[96:127]  = k[96:127]  ^ res[64:95];
        t = sub_word(res[96:127]);
        res[128:159] = k[128:159] ^ t;
        res[160:191] = k[160:191] ^ res[128:159];
        res[192:223] = k[192:223] ^ res[160:191];
        res[224:255] = k[224:255] ^ res[192:223];
        return res;
    endfunction

    state_t           state, state_nxt;
    logic [0:255]     work, work_nxt;
    logic [0:4]       r;
    logic [0:IDX_W-1] idx;
    logic             accept;

    assign accept   = key_v_i & key_ready_o;
    assign work_nxt = round_key(work, r);

`ifdef AES_KS_REVERSE_EN
    logic         dir;
    logic [0:127] rk_buf [0:NUM_RK-1];
    logic [3:0]   lo_sel, hi_sel;

    // Step r yields round keys 2r and 2r+1; the upper half of step 7 would be key 15.
    assign lo_sel = {r[2:4], 1'b0};
    assign hi_sel = {r[2:4], 1'b1};

    always_ff @(posedge clk_i) begin
        if (accept) begin
            rk_buf[0] <= key_i[0:127];
            rk_buf[1] <= key_i[128:255];
        end else if (state == EXPAND) begin
            rk_buf[lo_sel] <= work_nxt[0:127];
            if (r != 5'd7)
                rk_buf[hi_sel] <= work_nxt[128:255];
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef AES_KS_REVERSE_EN
            IDLE:     if (accept) state_nxt = dir_i ? EXPAND : EMIT_LO;
            EXPAND:   if (r == 5'd7) state_nxt = EMIT_BUF;
            EMIT_BUF: if (rk_ready_i && idx == '0) state_nxt = IDLE;
`else
            IDLE:     if (accept) state_nxt = EMIT_LO;
`endif
            EMIT_LO:  if (rk_ready_i) state_nxt = (idx == LAST_IDX) ? IDLE : EMIT_HI;
            EMIT_HI:  if (rk_ready_i) state_nxt = EMIT_LO;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_ready_o = state == IDLE;
        busy_o      = state != IDLE;
        rk_o        = state == EMIT_LO ? work[0:127] : state == EMIT_HI ? work[128:255] : '0;
`ifdef AES_KS_REVERSE_EN
        rk_v_o      = state == EMIT_LO || state == EMIT_HI || state == EMIT_BUF;
        if (state == EMIT_BUF)
            rk_o = rk_buf[idx];
        rk_last_o   = rk_v_o && (dir ? idx == '0 : idx == LAST_IDX);
`else
        rk_v_o      = state == EMIT_LO || state == EMIT_HI;
        rk_last_o   = rk_v_o && idx == LAST_IDX;
`endif
        rk_idx_o    = rk_v_o ? idx : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            work <= '0;
            r    <= 5'd1;
            idx  <= '0;
`ifdef AES_KS_REVERSE_EN
            dir  <= 1'b0;
`endif
        end else if (accept) begin
            work <= key_i;
            r    <= 5'd1;
`ifdef AES_KS_REVERSE_EN
            idx  <= dir_i ? LAST_IDX : '0;
            dir  <= dir_i;
`else
            idx  <= '0;
`endif
        end else if (state == EMIT_LO && rk_ready_i && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
        end else if (state == EMIT_HI && rk_ready_i) begin
            work <= work_nxt;
            r    <= r + 5'd1;
            idx  <= idx + 1'b1;
`ifdef AES_KS_REVERSE_EN
        end else if (state == EXPAND) begin
            work <= work_nxt;
            r    <= r + 5'd1;
        end else if (state == EMIT_BUF && rk_ready_i && idx != '0) begin
            idx <= idx - 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_aes256_key_sched.sv
// tb_aes256_key_sched: scoreboard bench for the forward AES-256 key scheduler
module tb_aes256_key_sched;
    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [0:255] key_i = '0;
    logic         key_v_i = 1'b0;
    logic         key_ready_o;
    logic [0:127] rk_o;
    logic [0:3]   rk_idx_o;
    logic         rk_last_o;
    logic         rk_v_o;
    logic         rk_ready_i = 1'b0;
    logic         busy_o;

    aes256_key_sched dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .key_i(key_i), .key_v_i(key_v_i),
        .key_ready_o(key_ready_o), .rk_o(rk_o), .rk_idx_o(rk_idx_o), .rk_last_o(rk_last_o),
        .rk_v_o(rk_v_o), .rk_ready_i(rk_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           mode = 0;
    int           last_cyc = -1;
    int           acc_cyc = 0;
    logic [7:0]   sbox [256];
    logic [127:0] model_rk [15];
    logic [127:0] obs_rk [15];
    exp_t         sb [$];
    exp_t         e;
    logic         held_v = 1'b0;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    logic         held_last;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse then the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Classic word-by-word key expansion, w[0..59]
    task automatic model_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = sw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic push_expected();
        for (int j = 0; j < 15; j++) sb.push_back('{model_rk[j], 4'(j), j == 14});
    endtask

    // Output monitor: drives rk_ready_i, pops the scoreboard on each transfer, checks stalls
    initial forever begin
        @(negedge clk_i);
        if (!reset_n_i) held_v = 1'b0;
        rk_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (held_v) begin
            total++;
            if (rk_v_o !== 1'b1 || rk_o !== held_rk || rk_idx_o !== held_idx || rk_last_o !== held_last) begin
                bad++;
                $display("FAIL stall_hold: got v=%b idx=%0d last=%b rk=%h, want v=1 idx=%0d last=%b rk=%h",
                         rk_v_o, rk_idx_o, rk_last_o, rk_o, held_idx, held_last, held_rk);
            end
        end
        if (rk_v_o && rk_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_xfer: got idx=%0d rk=%h, want no transfer", rk_idx_o, rk_o);
            end else begin
                e = sb.pop_front();
                if (rk_o !== e.rk || rk_idx_o !== e.idx || rk_last_o !== e.last) begin
                    bad++;
                    $display("FAIL xfer: got idx=%0d last=%b rk=%h, want idx=%0d last=%b rk=%h",
                             rk_idx_o, rk_last_o, rk_o, e.idx, e.last, e.rk);
                end
            end
            if (rk_idx_o < 4'd15) obs_rk[rk_idx_o] = rk_o;
            if (rk_last_o) last_cyc = cyc;
        end
        held_v    = rk_v_o && !rk_ready_i;
        held_rk   = rk_o;
        held_idx  = rk_idx_o;
        held_last = rk_last_o;
    end

    task automatic send_key(input logic [255:0] k);
        @(negedge clk_i);
        key_i   = k;
        key_v_i = 1'b1;
        model_expand(k);
        push_expected();
        acc_cyc = cyc;
        @(negedge clk_i);
        key_v_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #2;
        total++; if (rk_v_o !== 1'b0) begin bad++; $display("FAIL reset_rk_v: got %b want 0", rk_v_o); end
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL reset_key_ready: got %b want 1", key_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (rk_o !== '0) begin bad++; $display("FAIL reset_rk: got %h want 0", rk_o); end
        total++; if (rk_idx_o !== 4'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", rk_idx_o); end
        total++; if (rk_last_o !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", rk_last_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_c3_forward();
        mode = 0;
        send_key(KEY_C3);
        total++;
        if (rk_v_o !== 1'b1 || rk_idx_o !== 4'd0 || busy_o !== 1'b1 || key_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL c3_latency: got v=%b idx=%0d busy=%b ready=%b, want v=1 idx=0 busy=1 ready=0",
                     rk_v_o, rk_idx_o, busy_o, key_ready_o);
        end
        wait_drain(100);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL c3_drain: got %0d pending want 0", sb.size()); end
        total++; if (last_cyc - acc_cyc != 15) begin bad++; $display("FAIL c3_length: got %0d cycles want 15", last_cyc - acc_cyc); end
        total++; if (obs_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL c3_rk0: got %h want 000102030405060708090a0b0c0d0e0f", obs_rk[0]); end
        total++; if (obs_rk[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin bad++; $display("FAIL c3_rk1: got %h want 101112131415161718191a1b1c1d1e1f", obs_rk[1]); end
        total++; if (obs_rk[2] !== 128'ha573c29fa176c498a97fce93a572c09c) begin bad++; $display("FAIL c3_rk2: got %h want a573c29fa176c498a97fce93a572c09c", obs_rk[2]); end
        total++; if (obs_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin bad++; $display("FAIL c3_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", obs_rk[14]); end
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL c3_ready_after: got %b want 1", key_ready_o); end
    endtask

    task automatic test_a3_forward();
        mode = 0;
        send_key(KEY_A3);
        wait_drain(100);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL a3_drain: got %0d pending want 0", sb.size()); end
        total++; if (obs_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin bad++; $display("FAIL a3_rk2: got %h want 9ba354118e6925afa51a8b5f2067fcde", obs_rk[2]); end
        total++; if (obs_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin bad++; $display("FAIL a3_rk14: got %h want fe4890d1e6188d0b046df344706c631e", obs_rk[14]); end
    endtask

    task automatic test_random_stall();
        mode = 1;
        send_key(KEY_C3);
        total++; if (rk_v_o !== 1'b1 || rk_idx_o !== 4'd0) begin bad++; $display("FAIL stall_latency: got v=%b idx=%0d want v=1 idx=0", rk_v_o, rk_idx_o); end
        wait_drain(600);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_drain: got %0d pending want 0", sb.size()); end
        for (int j = 0; j < 15; j++) begin
            total++;
            if (obs_rk[j] !== model_rk[j]) begin bad++; $display("FAIL stall_rk%0d: got %h want %h", j, obs_rk[j], model_rk[j]); end
        end
        mode = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 0;
        @(negedge clk_i);
        key_i   = KEY_A3;
        key_v_i = 1'b1;
        model_expand(KEY_A3);
        push_expected();
        @(negedge clk_i);
        key_i = KEY_C3;
        model_expand(KEY_C3);
        for (n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (key_ready_o) break;
        end
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", key_ready_o); end
        total++; if (cyc != last_cyc + 1) begin bad++; $display("FAIL b2b_accept_cycle: got %0d want %0d", cyc, last_cyc + 1); end
        push_expected();
        @(negedge clk_i);
        key_v_i = 1'b0;
        total++;
        if (rk_v_o !== 1'b1 || rk_idx_o !== 4'd0 || rk_o !== model_rk[0]) begin
            bad++;
            $display("FAIL b2b_rk0: got v=%b idx=%0d rk=%h, want v=1 idx=0 rk=%h", rk_v_o, rk_idx_o, rk_o, model_rk[0]);
        end
        wait_drain(100);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_reset_midstream();
        int n;
        mode = 0;
        send_key(KEY_C3);
        for (n = 0; n < 50; n++) begin
            if (rk_v_o && rk_idx_o == 4'd6) break;
            @(negedge clk_i);
        end
        total++; if (rk_idx_o !== 4'd6) begin bad++; $display("FAIL mid_reach_idx6: got %0d want 6", rk_idx_o); end
        #1 reset_n_i = 1'b0;
        #1;
        total++;
        if (rk_v_o !== 1'b0 || key_ready_o !== 1'b1 || rk_idx_o !== 4'd0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b ready=%b idx=%0d busy=%b, want v=0 ready=1 idx=0 busy=0",
                     rk_v_o, key_ready_o, rk_idx_o, busy_o);
        end
        sb.delete();
        @(negedge clk_i);
        #2 reset_n_i = 1'b1;
        send_key(KEY_C3);
        total++; if (rk_v_o !== 1'b1 || rk_idx_o !== 4'd0) begin bad++; $display("FAIL mid_restart: got v=%b idx=%0d want v=1 idx=0", rk_v_o, rk_idx_o); end
        wait_drain(100);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL mid_drain: got %0d pending want 0", sb.size()); end
        total++; if (obs_rk[14] !== model_rk[14]) begin bad++; $display("FAIL mid_rk14: got %h want %h", obs_rk[14], model_rk[14]); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_c3_forward();
        test_a3_forward();
        test_random_stall();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
